// File: rtl/jtkcpu_idxseq.sv
// rtl/jtkcpu_idxseq.sv - indexed-addressing sequencer: postbyte decode, offset fetch, EA, one-level indirection
module jtkcpu_idxseq #(
    parameter int AW         = 16,
    parameter bit IND_INC_OK = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    postbyte,
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    input  logic [AW-1:0] u,
    input  logic [AW-1:0] s,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    input  logic [AW-1:0] pc,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    input  logic          rd_ack,
    output logic          busy,
    output logic          ea_valid,
    output logic [AW-1:0] ea,
    output logic [1:0]    pc_adv,
    output logic          wb_en,
    output logic [1:0]    wb_sel,
    output logic [AW-1:0] wb_val,
    output logic          illegal
);

    localparam logic [1:0] PBYTES = 2'(AW / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFS,
        S_IND,
        S_DONE,
        S_ILL
    } state_t;

    state_t        state_q;
    logic [3:0]    mode_q;
    logic          ind_q;
    logic [AW-1:0] rbase_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [AW-1:0] fp_q;
    logic [15:0]   ofs_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] iaddr_q;
    logic [1:0]    cnt_q;
    logic [AW-1:0] ea_q;
    logic [1:0]    adv_q;
    logic          wb_q;
    logic [1:0]    sel_q;
    logic [AW-1:0] wbv_q;

    function automatic logic [AW-1:0] step(input logic [1:0] m, input logic [AW-1:0] r);
        case (m)
            2'd0:    step = r + AW'(1);
            2'd1:    step = r + AW'(2);
            2'd2:    step = r - AW'(1);
            default: step = r - AW'(2);
        endcase
    endfunction

    // Offset-based modes take the fetched bytes; PC-relative modes use the pointer past them.
    function automatic logic [AW-1:0] calc_ea(input logic [3:0] m, input logic [AW-1:0] r,
                                              input logic [7:0] av, input logic [7:0] bv,
                                              input logic [15:0] ofs, input logic [AW-1:0] fpv);
        case (m)
            4'h2, 4'h3: calc_ea = step(m[1:0], r);
            4'h5:       calc_ea = r + AW'($signed(bv));
            4'h6:       calc_ea = r + AW'($signed(av));
            4'h8:       calc_ea = r + AW'($signed(ofs[7:0]));
            4'h9:       calc_ea = r + AW'($signed(ofs));
            4'hB:       calc_ea = r + AW'($signed({av, bv}));
            4'hC:       calc_ea = fpv + AW'($signed(ofs[7:0]));
            4'hD:       calc_ea = fpv + AW'($signed(ofs));
            4'hF:       calc_ea = AW'(ofs);
            default:    calc_ea = r;
        endcase
    endfunction

    logic [AW-1:0] r_in;
    logic          ind_in;
    logic          ill_in;
    logic          wb_in;
    logic [1:0]    nbytes_in;
    logic [AW-1:0] ea_in;
    logic [AW-1:0] wbv_in;
    logic [15:0]   ofs_nx;
    logic [AW-1:0] fp_nx;
    logic [AW-1:0] ptr_nx;
    logic [AW-1:0] ea_ofs;

    always_comb begin
        case (postbyte[6:5])
            2'd0:    r_in = x;
            2'd1:    r_in = y;
            2'd2:    r_in = u;
            default: r_in = s;
        endcase
        ind_in    = postbyte[7] & postbyte[4];
        ill_in    = 1'b0;
        wb_in     = 1'b0;
        nbytes_in = 2'd0;
        if (postbyte[7]) begin
            case (postbyte[3:0])
                4'h8, 4'hC:       nbytes_in = 2'd1;
                4'h9, 4'hD, 4'hF: nbytes_in = 2'd2;
                4'h7, 4'hA, 4'hE: ill_in    = 1'b1;
                default:          nbytes_in = 2'd0;
            endcase
            if (postbyte[3:0] == 4'hF && !ind_in)
                ill_in = 1'b1;
            if (ind_in && !IND_INC_OK && (postbyte[3:0] == 4'h0 || postbyte[3:0] == 4'h2))
                ill_in = 1'b1;
            wb_in = (postbyte[3:2] == 2'b00);
        end
        ea_in  = postbyte[7] ? calc_ea(postbyte[3:0], r_in, a, b, 16'h0000, pc)
                             : r_in + AW'($signed(postbyte[4:0]));
        wbv_in = step(postbyte[1:0], r_in);
        ofs_nx = {ofs_q[7:0], rd_data};
        fp_nx  = fp_q + AW'(1);
        ptr_nx = {ptr_q[AW-9:0], rd_data};
        ea_ofs = calc_ea(mode_q, rbase_q, a_q, b_q, ofs_nx, fp_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            ind_q   <= 1'b0;
            rbase_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fp_q    <= '0;
            ofs_q   <= '0;
            ptr_q   <= '0;
            iaddr_q <= '0;
            cnt_q   <= '0;
            ea_q    <= '0;
            adv_q   <= '0;
            wb_q    <= 1'b0;
            sel_q   <= '0;
            wbv_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q  <= postbyte[3:0];
                    ind_q   <= ind_in;
                    rbase_q <= r_in;
                    a_q     <= a;
                    b_q     <= b;
                    fp_q    <= pc;
                    ofs_q   <= '0;
                    ptr_q   <= '0;
                    cnt_q   <= nbytes_in;
                    adv_q   <= nbytes_in;
                    wb_q    <= wb_in;
                    sel_q   <= postbyte[6:5];
                    wbv_q   <= wbv_in;
                    if (ill_in) begin
                        state_q <= S_ILL;
                    end else if (nbytes_in != 2'd0) begin
                        state_q <= S_OFS;
                    end else if (ind_in) begin
                        iaddr_q <= ea_in;
                        cnt_q   <= PBYTES;
                        state_q <= S_IND;
                    end else begin
                        ea_q    <= ea_in;
                        state_q <= S_DONE;
                    end
                end
                S_OFS: if (rd_ack) begin
                    ofs_q <= ofs_nx;
                    fp_q  <= fp_nx;
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        if (ind_q) begin
                            iaddr_q <= ea_ofs;
                            cnt_q   <= PBYTES;
                            state_q <= S_IND;
                        end else begin
                            ea_q    <= ea_ofs;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_IND: if (rd_ack) begin
                    ptr_q   <= ptr_nx;
                    iaddr_q <= iaddr_q + AW'(1);
                    cnt_q   <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        ea_q    <= ptr_nx;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ILL:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rd_req   = (state_q == S_OFS) || (state_q == S_IND);
    assign rd_addr  = (state_q == S_OFS) ? fp_q : ((state_q == S_IND) ? iaddr_q : '0);
    assign ea_valid = (state_q == S_DONE);
    assign wb_en    = (state_q == S_DONE) && wb_q;
    assign illegal  = (state_q == S_ILL);
    assign ea       = ea_q;
    assign pc_adv   = adv_q;
    assign wb_sel   = sel_q;
    assign wb_val   = wbv_q;

endmodule

// File: tb/tb_jtkcpu_idxseq.sv
// tb/tb_jtkcpu_idxseq.sv - directed bench for jtkcpu_idxseq, AW=16/IND_INC_OK=0 and AW=24/IND_INC_OK=1 side by side
module tb_jtkcpu_idxseq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  postbyte = '0;
    logic [23:0] x = '0, y = '0, u = '0, s = '0, pc = '0;
    logic [7:0]  a = '0, b = '0;

    logic        rd_req16, busy16, ea_valid16, wb_en16, illegal16, rd_ack16;
    logic [15:0] rd_addr16, ea16, wb_val16;
    logic [1:0]  pc_adv16, wb_sel16;
    logic [7:0]  rd_data16;

    logic        rd_req24, busy24, ea_valid24, wb_en24, illegal24, rd_ack24;
    logic [23:0] rd_addr24, ea24, wb_val24;
    logic [1:0]  pc_adv24, wb_sel24;
    logic [7:0]  rd_data24;

    logic [7:0]  mem [0:65535];
    int          ack_dly = 0;
    logic [23:0] log16[$];
    logic [23:0] log24[$];

    int          n_chk = 0;
    int          n_err = 0;

    bit          ev_c[2], ill_c[2], wb_c[2];
    int          cyc_c[2];
    logic [23:0] ea_c[2], wv_c[2];
    logic [1:0]  adv_c[2], sel_c[2];

    always #5 clk = ~clk;

    jtkcpu_idxseq #(.AW(16), .IND_INC_OK(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .postbyte(postbyte),
        .x(x[15:0]), .y(y[15:0]), .u(u[15:0]), .s(s[15:0]), .a(a), .b(b), .pc(pc[15:0]),
        .rd_req(rd_req16), .rd_addr(rd_addr16), .rd_data(rd_data16), .rd_ack(rd_ack16),
        .busy(busy16), .ea_valid(ea_valid16), .ea(ea16), .pc_adv(pc_adv16),
        .wb_en(wb_en16), .wb_sel(wb_sel16), .wb_val(wb_val16), .illegal(illegal16)
    );

    jtkcpu_idxseq #(.AW(24), .IND_INC_OK(1'b1)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .postbyte(postbyte),
        .x(x), .y(y), .u(u), .s(s), .a(a), .b(b), .pc(pc),
        .rd_req(rd_req24), .rd_addr(rd_addr24), .rd_data(rd_data24), .rd_ack(rd_ack24),
        .busy(busy24), .ea_valid(ea_valid24), .ea(ea24), .pc_adv(pc_adv24),
        .wb_en(wb_en24), .wb_sel(wb_sel24), .wb_val(wb_val24), .illegal(illegal24)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        int w;
        rd_ack16 = 1'b0; rd_data16 = '0; w = 0;
        forever begin
            @(posedge clk); #1;
            rd_ack16 = 1'b0;
            if (rd_req16) begin
                if (w >= ack_dly) begin
                    rd_data16 = mem[rd_addr16];
                    rd_ack16  = 1'b1;
                    w = 0;
                    log16.push_back(24'(rd_addr16));
                end else w++;
            end else w = 0;
        end
    end

    initial begin
        int w;
        rd_ack24 = 1'b0; rd_data24 = '0; w = 0;
        forever begin
            @(posedge clk); #1;
            rd_ack24 = 1'b0;
            if (rd_req24) begin
                if (w >= ack_dly) begin
                    rd_data24 = mem[rd_addr24[15:0]];
                    rd_ack24  = 1'b1;
                    w = 0;
                    log24.push_back(rd_addr24);
                end else w++;
            end else w = 0;
        end
    end

    task automatic run(input logic [7:0] pb, input logic [23:0] pcv);
        bit d0, d1;
        log16.delete(); log24.delete();
        for (int k = 0; k < 2; k++) begin
            ev_c[k] = 0; ill_c[k] = 0; wb_c[k] = 0; cyc_c[k] = 0;
            ea_c[k] = '0; wv_c[k] = '0; adv_c[k] = '0; sel_c[k] = '0;
        end
        d0 = 0; d1 = 0;
        @(posedge clk); #1;
        postbyte = pb; pc = pcv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 60 && !(d0 && d1); i++) begin
            @(negedge clk);
            if (!d0 && (ea_valid16 || illegal16)) begin
                d0 = 1; cyc_c[0] = i; ev_c[0] = ea_valid16; ill_c[0] = illegal16;
                ea_c[0] = 24'(ea16); adv_c[0] = pc_adv16; wb_c[0] = wb_en16;
                sel_c[0] = wb_sel16; wv_c[0] = 24'(wb_val16);
            end
            if (!d1 && (ea_valid24 || illegal24)) begin
                d1 = 1; cyc_c[1] = i; ev_c[1] = ea_valid24; ill_c[1] = illegal24;
                ea_c[1] = ea24; adv_c[1] = pc_adv24; wb_c[1] = wb_en24;
                sel_c[1] = wb_sel24; wv_c[1] = wb_val24;
            end
        end
    endtask

    task automatic exp_op(input string tag, input int k, input bit ev, input int cy,
                          input logic [23:0] e, input int adv, input bit wb, input logic [23:0] wv);
        string t;
        t = $sformatf("%s_%0d", tag, (k == 0) ? 16 : 24);
        chk({t, "_ev"}, 32'(ev_c[k]), 32'(ev));
        chk({t, "_ill"}, 32'(ill_c[k]), 32'(!ev));
        chk({t, "_cyc"}, 32'(cyc_c[k]), 32'(cy));
        if (ev) begin
            chk({t, "_ea"}, 32'(ea_c[k]), 32'(e));
            chk({t, "_adv"}, 32'(adv_c[k]), 32'(adv));
            chk({t, "_wb"}, 32'(wb_c[k]), 32'(wb));
            if (wb) chk({t, "_wbval"}, 32'(wv_c[k]), 32'(wv));
        end
    endtask

    initial begin
        mem[16'h0100] = 8'h80; mem[16'h0101] = 8'h00;
        mem[16'h0200] = 8'h12; mem[16'h0201] = 8'h34;
        mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD; mem[16'h1236] = 8'hEF;
        mem[16'h3000] = 8'h45; mem[16'h3001] = 8'h67; mem[16'h3002] = 8'h89;
        mem[16'h0300] = 8'h00; mem[16'h0301] = 8'h10;
        mem[16'h0400] = 8'hFE;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_rdreq", 32'(rd_req16), 32'd0);
        chk("rst_ea", 32'(ea16), 32'd0);
        chk("rst_eav", 32'(ea_valid16), 32'd0);
        chk("rst_wbval", 32'(wb_val16), 32'd0);
        chk("rst_ill", 32'(illegal16), 32'd0);
        chk("rst_ea24", 32'(ea24), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        x = 24'h001000;
        run(8'h1F, 24'h0);
        exp_op("t1", 0, 1, 1, 24'h000FFF, 0, 0, 0);
        exp_op("t1", 1, 1, 1, 24'h000FFF, 0, 0, 0);
        chk("t1_reads", 32'(log16.size() + log24.size()), 32'd0);

        x = 24'h002000;
        run(8'h81, 24'h0);
        exp_op("t2", 0, 1, 1, 24'h002000, 0, 1, 24'h002002);
        exp_op("t2", 1, 1, 1, 24'h002000, 0, 1, 24'h002002);
        chk("t2_sel", 32'(sel_c[0]), 32'd0);

        x = 24'h001000; ack_dly = 2;
        run(8'h89, 24'h000100);
        exp_op("t3", 0, 1, 7, 24'h009000, 2, 0, 0);
        exp_op("t3", 1, 1, 7, 24'hFF9000, 2, 0, 0);
        chk("t3_nrd", 32'(log16.size()), 32'd2);
        if (log16.size() == 2) begin
            chk("t3_addr0", 32'(log16[0]), 32'h0100);
            chk("t3_addr1", 32'(log16[1]), 32'h0101);
        end
        ack_dly = 0;

        run(8'h9F, 24'h000200);
        exp_op("t4", 0, 1, 5, 24'h00ABCD, 2, 0, 0);
        exp_op("t4", 1, 1, 6, 24'hABCDEF, 2, 0, 0);
        chk("t4_nrd16", 32'(log16.size()), 32'd4);
        chk("t4_nrd24", 32'(log24.size()), 32'd5);
        if (log24.size() == 5) chk("t4_addr4_24", 32'(log24[4]), 32'h001236);

        x = 24'h003000;
        run(8'h90, 24'h0);
        exp_op("t5a", 0, 0, 1, 0, 0, 0, 0);
        exp_op("t5a", 1, 1, 4, 24'h456789, 0, 1, 24'h003001);
        chk("t5a_hold16", 32'(ea16), 32'h0000ABCD);
        chk("t5a_nrd16", 32'(log16.size()), 32'd0);

        run(8'h87, 24'h0);
        exp_op("t5b", 0, 0, 1, 0, 0, 0, 0);
        exp_op("t5b", 1, 0, 1, 0, 0, 0, 0);
        run(8'h8F, 24'h0);
        exp_op("t5c", 0, 0, 1, 0, 0, 0, 0);
        exp_op("t5c", 1, 0, 1, 0, 0, 0, 0);
        run(8'h8A, 24'h0);
        exp_op("t5d", 0, 0, 1, 0, 0, 0, 0);

        y = 24'h000010; a = 8'hF0;
        run(8'hA6, 24'h0);
        exp_op("a_r", 0, 1, 1, 24'h000000, 0, 0, 0);
        exp_op("a_r", 1, 1, 1, 24'h000000, 0, 0, 0);

        s = 24'h000001;
        run(8'hE3, 24'h0);
        exp_op("dds", 0, 1, 1, 24'h00FFFF, 0, 1, 24'h00FFFF);
        exp_op("dds", 1, 1, 1, 24'hFFFFFF, 0, 1, 24'hFFFFFF);
        chk("dds_sel", 32'(sel_c[0]), 32'd3);

        x = 24'h001000; a = 8'h92; b = 8'h34;
        run(8'h8B, 24'h0);
        exp_op("d_r", 0, 1, 1, 24'h00A234, 0, 0, 0);
        exp_op("d_r", 1, 1, 1, 24'hFFA234, 0, 0, 0);

        run(8'h8D, 24'h000300);
        exp_op("n16pc", 0, 1, 3, 24'h000312, 2, 0, 0);
        run(8'h8C, 24'h000400);
        exp_op("n8pc", 0, 1, 2, 24'h0003FF, 1, 0, 0);
        exp_op("n8pc", 1, 1, 2, 24'h0003FF, 1, 0, 0);

        ack_dly = 30;
        @(posedge clk); #1;
        postbyte = 8'h89; pc = 24'h000100; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_pre_req", 32'(rd_req16), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_req16", 32'(rd_req16), 32'd0);
        chk("t6_busy16", 32'(busy16), 32'd0);
        chk("t6_req24", 32'(rd_req24), 32'd0);
        chk("t6_busy24", 32'(busy24), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ack_dly = 0;
        x = 24'h001000;
        run(8'h84, 24'h0);
        exp_op("t6", 0, 1, 1, 24'h001000, 0, 0, 0);
        exp_op("t6", 1, 1, 1, 24'h001000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jtkcpu_idxseq.md
Name: jtkcpu_idxseq

Overview:
Indexed-addressing sequencer for the KCPU core. It decodes an indexed postbyte and fetches any offset bytes from the instruction stream. It then computes the effective address (EA) and optionally follows one level of indirection. Auto-increment/decrement writebacks go to the register file. It sits between the instruction decoder and the bus unit, and generalises the combinational postbyte decode into a multi-cycle engine with a configurable address width.

Parameters:
AW, 16, address/register width in bits; multiple of 8, range 16..24; indirect pointers are AW/8 bytes, big-endian.
IND_INC_OK, 0, 1 = indirect single-step ,R+ / ,-R are legal; 0 = they raise illegal.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin decode; sampled only in IDLE
postbyte  in  8  indexed postbyte, sampled with start
x, y, u, s  in  AW each  index registers, reg field 0..3
a, b  in  8 each  accumulators; D = {a,b}
pc  in  AW  address of first byte after postbyte, sampled with start
rd_req  out  1  bus read request
rd_addr  out  AW  read address, stable while rd_req=1
rd_data  in  8  read data, valid on rd_ack cycle
rd_ack  in  1  read complete
busy  out  1  high in every state except IDLE
ea_valid  out  1  one-cycle pulse, EA ready
ea  out  AW  effective address, held until next ea_valid
pc_adv  out  2  offset bytes consumed (0..2), valid with ea_valid
wb_en  out  1  one-cycle pulse with ea_valid on auto inc/dec
wb_sel  out  2  register written back (reg field)
wb_val  out  AW  new register value
illegal  out  1  one-cycle pulse on an illegal postbyte

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs are 0, including rd_req, ea and wb_val. Reset mid-read drops rd_req immediately and abandons the operation.
- Postbyte fields: R = postbyte[6:5]. If postbyte[7]=0, EA = R + sext(postbyte[4:0]) with no indirection. If postbyte[7]=1, ind = postbyte[4] and mode = postbyte[3:0].
- Mode table:
  - 0 ,R+ : EA = R; wb = R+1.
  - 1 ,R++ : EA = R; wb = R+2.
  - 2 ,-R : EA = R-1; wb = R-1.
  - 3 ,--R : EA = R-2; wb = R-2.
  - 4 ,R : EA = R.
  - 5 B,R : EA = R + sext(b).
  - 6 A,R : EA = R + sext(a).
  - 8 n8,R : 1 byte, sign-extended.
  - 9 n16,R : 2 bytes, high byte first, sign-extended.
  - B D,R : EA = R + sext({a,b}).
  - C n8,PC and D n16,PC : base = pc + bytes consumed.
  - F : extended; 2 bytes form a zero-extended address; legal only with ind=1.
- Illegal cases: modes 7, A, E; mode F with ind=0; ind=1 with mode 0 or 2 when IND_INC_OK=0.
- All arithmetic is modulo 2^AW.
- States:
  - IDLE: on start, latch inputs and the fetch pointer fp = pc. Go to ILL if illegal, else OFS if the mode needs offset bytes, else IND if ind=1, else DONE.
  - OFS: rd_req=1, rd_addr=fp. On rd_ack, shift rd_data into the offset register and increment fp. After the last byte go to IND if ind=1, else DONE.
  - IND: reads AW/8 bytes at EA, EA+1, ...; on rd_ack after each byte, shift rd_data into the pointer register and increment the read address. After the last byte, EA = pointer; go to DONE.
  - DONE: ea_valid=1 and wb_en if applicable; return to IDLE.
  - ILL: illegal=1; no ea_valid, no wb_en; return to IDLE.
- Latency: a no-fetch mode gives ea_valid one cycle after start. Each bus byte adds (cycles to rd_ack) + 0, with the next request issued on the cycle after the ack.
- wb_en fires at DONE even when ind=1; wb_val is the non-indirect inc/dec value.
- start while busy is ignored. Register inputs are sampled only at start.
- rd_ack while rd_req=0 is ignored.

Test Plan:
1. X=0x1000, postbyte 0x1F, start -> ea_valid at cycle+1, ea=0x0FFF, pc_adv=0, rd_req never asserted.
2. X=0x2000, postbyte 0x81 -> ea=0x2000, wb_en=1, wb_sel=0, wb_val=0x2002.
3. X=0x1000, pc=0x0100, postbyte 0x89, bytes 0x80,0x00, each ack delayed 2 cycles -> rd_addr 0x0100 then 0x0101, ea=0x9000, pc_adv=2.
4. postbyte 0x9F, pc=0x0200, stream 0x12,0x34, mem[0x1234]=0xAB, mem[0x1235]=0xCD -> 4 reads, ea=0xABCD; with AW=24, 5 reads and a 3-byte pointer.
5. postbyte 0x90 (IND_INC_OK=0), then postbyte 0x87 -> illegal pulse each time, no ea_valid. With IND_INC_OK=1, 0x90 yields ea = mem pointer at X and wb_val = X+1.
6. rst_n low during OFS while waiting for ack -> rd_req=0 and busy=0 immediately; after release, a fresh start with 0x84 gives ea=X.
